// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the memory controller to fetch or LSB, one transaction at a time.
// Define MEM_ARB_STARVE_GUARD_EN to let a waiting fetch win after STARVE_LIMIT LSB grants.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        rollback,
  input  logic        if_en,
  input  logic [31:0] if_pc,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        lsb_en,
  input  logic        lsb_wr,
  input  logic [31:0] lsb_addr,
  input  logic [2:0]  lsb_len,
  input  logic [31:0] lsb_w_data,
  output logic        lsb_done,
  output logic [31:0] lsb_r_data,
  output logic        mc_en,
  output logic        mc_wr,
  output logic [31:0] mc_addr,
  output logic [2:0]  mc_len,
  output logic [31:0] mc_wdata,
  input  logic        mc_done,
  input  logic [31:0] mc_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LSB, BUBBLE} state_t;
  state_t state_q, state_d;
  logic        mc_en_q, mc_en_d, mc_wr_q, mc_wr_d;
  logic [31:0] mc_addr_q, mc_addr_d, mc_wdata_q, mc_wdata_d;
  logic [2:0]  mc_len_q, mc_len_d;
  logic        if_done_q, if_done_d, lsb_done_q, lsb_done_d;
  logic [31:0] if_data_q, if_data_d, lsb_r_data_q, lsb_r_data_d;
  logic        squash_q, squash_d, pend_q, pend_d;
  logic [31:0] pend_data_q, pend_data_d, fin_data;
  logic        idle, busy, rd, fin, sq, force_if, grant_if, grant_lsb;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_limit
    $error("mem_arbiter: STARVE_LIMIT must be 1..7");
  end

  assign idle      = state_q == IDLE;
  assign busy      = state_q == BUSY_IF || state_q == BUSY_LSB;
  assign rd        = busy && !mc_wr_q;
  // A completion seen while frozen is held in pend_q and retired on the next enabled edge.
  assign fin       = busy && (mc_done || pend_q);
  assign fin_data  = pend_q ? pend_data_q : mc_rdata;
  assign sq        = squash_q || (rollback && rd);
  assign grant_if  = idle && !rollback && if_en && (!lsb_en || force_if);
  assign grant_lsb = idle && !rollback && lsb_en && !grant_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [2:0] starve_q, starve_d;
  assign force_if = starve_q == 3'(STARVE_LIMIT);
  always_comb
    starve_d = (grant_if || (idle && !if_en)) ? 3'd0 :
               (grant_lsb && if_en && !force_if) ? starve_q + 3'd1 : starve_q;
  always_ff @(posedge clk) begin
    if (!rst_n) starve_q <= 3'd0;
    else if (rdy) starve_q <= starve_d;
  end
`else
  assign force_if = 1'b0;
`endif

  always_comb
    state_d = grant_if ? BUSY_IF : grant_lsb ? BUSY_LSB : fin ? BUBBLE :
              (state_q == BUBBLE) ? IDLE : state_q;

  always_comb begin
    mc_en_d      = (grant_if || grant_lsb) ? 1'b1 : fin ? 1'b0 : mc_en_q;
    mc_wr_d      = grant_if ? 1'b0 : grant_lsb ? lsb_wr : mc_wr_q;
    mc_addr_d    = grant_if ? if_pc : grant_lsb ? lsb_addr : mc_addr_q;
    mc_len_d     = grant_if ? 3'd4 : grant_lsb ? lsb_len : mc_len_q;
    mc_wdata_d   = grant_lsb ? lsb_w_data : mc_wdata_q;
    if_done_d    = fin && state_q == BUSY_IF && !sq;
    lsb_done_d   = fin && state_q == BUSY_LSB && !sq;
    if_data_d    = if_done_d ? fin_data : if_data_q;
    lsb_r_data_d = lsb_done_d ? (mc_wr_q ? 32'h0 : fin_data) : lsb_r_data_q;
    squash_d     = fin ? 1'b0 : sq;
    pend_d       = !rdy && (pend_q || (busy && mc_done));
    pend_data_d  = (!rdy && busy && mc_done && !pend_q) ? mc_rdata : pend_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mc_en_q      <= 1'b0;
      mc_wr_q      <= 1'b0;
      mc_addr_q    <= 32'h0;
      mc_len_q     <= 3'd0;
      mc_wdata_q   <= 32'h0;
      if_done_q    <= 1'b0;
      lsb_done_q   <= 1'b0;
      if_data_q    <= 32'h0;
      lsb_r_data_q <= 32'h0;
      squash_q     <= 1'b0;
    end else if (rdy) begin
      state_q      <= state_d;
      mc_en_q      <= mc_en_d;
      mc_wr_q      <= mc_wr_d;
      mc_addr_q    <= mc_addr_d;
      mc_len_q     <= mc_len_d;
      mc_wdata_q   <= mc_wdata_d;
      if_done_q    <= if_done_d;
      lsb_done_q   <= lsb_done_d;
      if_data_q    <= if_data_d;
      lsb_r_data_q <= lsb_r_data_d;
      squash_q     <= squash_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q      <= 1'b0;
      pend_data_q <= 32'h0;
    end else begin
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
    end
  end

  assign mc_en      = mc_en_q;
  assign mc_wr      = mc_wr_q;
  assign mc_addr    = mc_addr_q;
  assign mc_len     = mc_len_q;
  assign mc_wdata   = mc_wdata_q;
  assign if_done    = if_done_q && rdy;
  assign lsb_done   = lsb_done_q && rdy;
  assign if_data    = if_data_q;
  assign lsb_r_data = lsb_r_data_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a latency-driven controller model.
module tb_mem_arbiter;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic clk = 0, rst_n = 0, rdy = 1, rollback = 0;
  logic if_en = 0, lsb_en = 0, lsb_wr = 0;
  logic [31:0] if_pc = 0, lsb_addr = 0, lsb_w_data = 0;
  logic [2:0] lsb_len = 0;
  logic if_done, lsb_done, mc_en, mc_wr;
  logic [31:0] if_data, lsb_r_data, mc_addr, mc_wdata;
  logic [2:0] mc_len;
  logic mc_done = 0;
  logic [31:0] mc_rdata = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  len;
    logic [31:0] wdata;
    logic        chk_wd;
  } grant_t;
  grant_t exp_grant[$];
  grant_t cur, held;
  logic [31:0] exp_if[$], exp_lsb[$], resp_q[$], d;
  int checks = 0, failures = 0, n_if = 0, n_lsb = 0, cyc = 0, fall_cyc = -10;
  int mc_lat = 4, mc_cnt = 0;
  logic prev_en = 0, prev_if = 0, prev_lsb = 0;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback(rollback),
    .if_en(if_en), .if_pc(if_pc), .if_done(if_done), .if_data(if_data),
    .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
    .lsb_w_data(lsb_w_data), .lsb_done(lsb_done), .lsb_r_data(lsb_r_data),
    .mc_en(mc_en), .mc_wr(mc_wr), .mc_addr(mc_addr), .mc_len(mc_len),
    .mc_wdata(mc_wdata), .mc_done(mc_done), .mc_rdata(mc_rdata)
  );

  always #5 clk = ~clk;

  // Controller model: completes mc_lat enabled cycles after a grant, data from resp_q.
  initial forever begin
    @(posedge clk); #1;
    mc_done = 0;
    if (!mc_en) mc_cnt = 0;
    else if (rdy) begin
      mc_cnt++;
      if (mc_cnt == mc_lat) begin
        mc_done = 1;
        mc_cnt = 0;
        if (resp_q.size() > 0) mc_rdata = resp_q.pop_front();
        else mc_rdata = 32'h0;
      end
    end
  end

  // Monitor: pops grant and done expectations when the DUT produces them.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      prev_en = 0; prev_if = 0; prev_lsb = 0;
    end else begin
      if (mc_en && !prev_en) begin
        checks++;
        if (exp_grant.size() == 0) begin
          failures++; $display("FAIL grant_unexpected addr=%h len=%0d wr=%b", mc_addr, mc_len, mc_wr);
        end else begin
          cur = exp_grant.pop_front();
          if (mc_wr !== cur.wr || mc_addr !== cur.addr || mc_len !== cur.len || (cur.chk_wd && mc_wdata !== cur.wdata)) begin
            failures++;
            $display("FAIL grant_fields got wr=%b addr=%h len=%0d wdata=%h exp wr=%b addr=%h len=%0d wdata=%h",
                     mc_wr, mc_addr, mc_len, mc_wdata, cur.wr, cur.addr, cur.len, cur.wdata);
          end
        end
        checks++;
        if (cyc - fall_cyc < 2) begin
          failures++; $display("FAIL grant_gap got=%0d cycles exp>=2", cyc - fall_cyc);
        end
        held = '{mc_wr, mc_addr, mc_len, mc_wdata, 1'b1};
      end else if (mc_en && prev_en) begin
        checks++;
        if (mc_wr !== held.wr || mc_addr !== held.addr || mc_len !== held.len || mc_wdata !== held.wdata) begin
          failures++; $display("FAIL mc_stable got addr=%h len=%0d exp addr=%h len=%0d", mc_addr, mc_len, held.addr, held.len);
        end
      end
      if (!mc_en && prev_en) fall_cyc = cyc;
      if (if_done) begin
        n_if++;
        checks++;
        if (exp_if.size() == 0) begin
          failures++; $display("FAIL if_done_unexpected data=%h", if_data);
        end else begin
          d = exp_if.pop_front();
          if (if_data !== d) begin failures++; $display("FAIL if_data got=%h exp=%h", if_data, d); end
        end
        if (prev_if) begin failures++; $display("FAIL if_done_width got=2+ cycles exp=1"); end
      end
      if (lsb_done) begin
        n_lsb++;
        checks++;
        if (exp_lsb.size() == 0) begin
          failures++; $display("FAIL lsb_done_unexpected data=%h", lsb_r_data);
        end else begin
          d = exp_lsb.pop_front();
          if (lsb_r_data !== d) begin failures++; $display("FAIL lsb_r_data got=%h exp=%h", lsb_r_data, d); end
        end
        if (prev_lsb) begin failures++; $display("FAIL lsb_done_width got=2+ cycles exp=1"); end
      end
      if (if_done && lsb_done) begin failures++; $display("FAIL both_done got=1 exp=0"); end
      prev_en = mc_en; prev_if = if_done; prev_lsb = lsb_done;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic run(input int t_if, input int t_lsb, input bit rel, input int budget);
    int n;
    n = 0;
    while ((n_if < t_if || n_lsb < t_lsb) && n < budget) begin
      tick();
      if (rel && if_done) if_en = 0;
      if (rel && lsb_done) lsb_en = 0;
      n++;
    end
    checks++;
    if (n_if < t_if || n_lsb < t_lsb) begin
      failures++; $display("FAIL run_timeout got if=%0d lsb=%0d exp if=%0d lsb=%0d", n_if, n_lsb, t_if, t_lsb);
    end
  endtask

  task automatic wait_mc_done(input int budget);
    int n;
    n = 0;
    while (!mc_done && n < budget) begin tick(); n++; end
    checks++;
    if (!mc_done) begin failures++; $display("FAIL mc_done_timeout got=0 exp=1"); end
  endtask

  task automatic test_reset();
    rst_n = 0; tick(); tick();
    checks++;
    if ({mc_en, mc_wr, if_done, lsb_done} !== 4'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {mc_en, mc_wr, if_done, lsb_done});
    end
    checks++;
    if (mc_addr !== 0 || mc_len !== 0 || mc_wdata !== 0 || if_data !== 0 || lsb_r_data !== 0) begin
      failures++; $display("FAIL reset_regs got addr=%h len=%0d wdata=%h exp 0", mc_addr, mc_len, mc_wdata);
    end
    rst_n = 1; tick();
  endtask

  task automatic test_if_only();
    int n;
    mc_lat = 5;
    resp_q.push_back(32'hDEADBEEF); exp_if.push_back(32'hDEADBEEF);
    exp_grant.push_back('{1'b0, 32'h1000, 3'd4, 32'h0, 1'b0});
    if_pc = 32'h1000; if_en = 1;
    tick();
    checks++;
    if (mc_en !== 1 || mc_addr !== 32'h1000 || mc_len !== 3'd4 || mc_wr !== 0) begin
      failures++; $display("FAIL if_grant got en=%b addr=%h len=%0d wr=%b exp 1/1000/4/0", mc_en, mc_addr, mc_len, mc_wr);
    end
    n = 0;
    while (!if_done && n < 20) begin tick(); n++; end
    checks++;
    if (n !== 5) begin failures++; $display("FAIL if_latency got=%0d exp=5", n); end
    checks++;
    if (if_done !== 1 || if_data !== 32'hDEADBEEF || mc_en !== 0) begin
      failures++; $display("FAIL if_complete got done=%b data=%h en=%b exp 1/deadbeef/0", if_done, if_data, mc_en);
    end
    resp_q.push_back(32'h0BADF00D); exp_if.push_back(32'h0BADF00D);
    exp_grant.push_back('{1'b0, 32'h1004, 3'd4, 32'h0, 1'b0});
    if_pc = 32'h1004;
    tick();
    checks++;
    if (mc_en !== 0 || if_done !== 0) begin
      failures++; $display("FAIL if_bubble got en=%b done=%b exp 0/0", mc_en, if_done);
    end
    tick();
    checks++;
    if (mc_en !== 1 || mc_addr !== 32'h1004) begin
      failures++; $display("FAIL if_regrant got en=%b addr=%h exp 1/1004", mc_en, mc_addr);
    end
    run(n_if + 1, n_lsb, 1, 40);
  endtask

  task automatic test_simultaneous();
    mc_lat = 3;
    resp_q.push_back(32'h0000BEEF); resp_q.push_back(32'hCAFEF00D);
    exp_grant.push_back('{1'b0, 32'h2000, 3'd2, 32'h55AA55AA, 1'b1});
    exp_grant.push_back('{1'b0, 32'h2004, 3'd4, 32'h0, 1'b0});
    exp_lsb.push_back(32'h0000BEEF); exp_if.push_back(32'hCAFEF00D);
    lsb_wr = 0; lsb_addr = 32'h2000; lsb_len = 3'd2; lsb_w_data = 32'h55AA55AA; if_pc = 32'h2004;
    if_en = 1; lsb_en = 1;
    tick();
    checks++;
    if (mc_en !== 1 || mc_addr !== 32'h2000 || mc_len !== 3'd2) begin
      failures++; $display("FAIL sim_lsb_first got en=%b addr=%h len=%0d exp 1/2000/2", mc_en, mc_addr, mc_len);
    end
    run(n_if + 1, n_lsb + 1, 1, 60);
  endtask

  task automatic test_starvation();
    int ni, nl;
    mc_lat = 2;
    ni = n_if; nl = n_lsb;
    for (int i = 0; i < 6; i++) begin
      resp_q.push_back(32'h100 + i);
      if (GUARD && i == 4) begin
        exp_grant.push_back('{1'b0, 32'h5000, 3'd4, 32'h0, 1'b0});
        exp_if.push_back(32'h100 + i);
      end else begin
        exp_grant.push_back('{1'b0, 32'h4000, 3'd4, 32'h0, 1'b1});
        exp_lsb.push_back(32'h100 + i);
      end
    end
    lsb_wr = 0; lsb_addr = 32'h4000; lsb_len = 3'd4; lsb_w_data = 32'h0; if_pc = 32'h5000;
    if_en = 1; lsb_en = 1;
    run(ni + (GUARD ? 1 : 0), nl + (GUARD ? 5 : 6), 0, 200);
    checks++;
    if (n_if !== ni + (GUARD ? 1 : 0)) begin
      failures++; $display("FAIL starve_if_grants got=%0d exp=%0d", n_if - ni, GUARD ? 1 : 0);
    end
    lsb_en = 0;
    resp_q.push_back(32'h5A5A0001); exp_if.push_back(32'h5A5A0001);
    exp_grant.push_back('{1'b0, 32'h5000, 3'd4, 32'h0, 1'b0});
    run(n_if + 1, n_lsb, 1, 40);
  endtask

  task automatic test_rollback_load();
    int nl;
    mc_lat = 6;
    rollback = 1; lsb_wr = 0; lsb_addr = 32'h3000; lsb_len = 3'd4; lsb_w_data = 32'h0; lsb_en = 1;
    tick(); tick();
    checks++;
    if (mc_en !== 0) begin failures++; $display("FAIL rb_idle_grant got en=%b exp=0", mc_en); end
    resp_q.push_back(32'h77777777);
    exp_grant.push_back('{1'b0, 32'h3000, 3'd4, 32'h0, 1'b1});
    rollback = 0;
    tick();
    checks++;
    if (mc_en !== 1) begin failures++; $display("FAIL rb_load_grant got en=%b exp=1", mc_en); end
    nl = n_lsb;
    tick(); tick();
    rollback = 1; lsb_en = 0;
    tick();
    rollback = 0;
    wait_mc_done(20);
    checks++;
    if (mc_en !== 1) begin failures++; $display("FAIL rb_hold got en=%b exp=1", mc_en); end
    tick(); tick(); tick();
    checks++;
    if (n_lsb !== nl || mc_en !== 0) begin
      failures++; $display("FAIL rb_no_done got dones=%0d en=%b exp 0/0", n_lsb - nl, mc_en);
    end
    resp_q.push_back(32'h12345678); exp_lsb.push_back(32'h12345678);
    exp_grant.push_back('{1'b0, 32'h3004, 3'd4, 32'h0, 1'b1});
    lsb_addr = 32'h3004; lsb_en = 1;
    run(n_if, n_lsb + 1, 1, 40);
    resp_q.push_back(32'h87654321);
    exp_grant.push_back('{1'b0, 32'h3008, 3'd1, 32'h0, 1'b1});
    lsb_addr = 32'h3008; lsb_len = 3'd1; lsb_en = 1; mc_lat = 3;
    tick();
    nl = n_lsb;
    wait_mc_done(20);
    rollback = 1; lsb_en = 0;
    tick();
    rollback = 0;
    tick(); tick();
    checks++;
    if (n_lsb !== nl) begin failures++; $display("FAIL rb_same_edge got dones=%0d exp=0", n_lsb - nl); end
  endtask

  task automatic test_rollback_store();
    int nl;
    mc_lat = 5;
    resp_q.push_back(32'hFFFFFFFF); exp_lsb.push_back(32'h0);
    exp_grant.push_back('{1'b1, 32'h30000, 3'd4, 32'h11223344, 1'b1});
    lsb_wr = 1; lsb_addr = 32'h30000; lsb_len = 3'd4; lsb_w_data = 32'h11223344; lsb_en = 1;
    tick();
    checks++;
    if (mc_en !== 1 || mc_wr !== 1 || mc_wdata !== 32'h11223344) begin
      failures++; $display("FAIL st_grant got en=%b wr=%b wdata=%h exp 1/1/11223344", mc_en, mc_wr, mc_wdata);
    end
    tick(); tick();
    rollback = 1;
    tick();
    rollback = 0;
    run(n_if, n_lsb + 1, 1, 40);
    resp_q.push_back(32'hEEEEEEEE); exp_lsb.push_back(32'h0);
    exp_grant.push_back('{1'b1, 32'h30004, 3'd4, 32'hA0B0C0D0, 1'b1});
    lsb_addr = 32'h30004; lsb_w_data = 32'hA0B0C0D0; lsb_en = 1; mc_lat = 3;
    nl = n_lsb;
    tick();
    wait_mc_done(20);
    rollback = 1; lsb_en = 0;
    tick();
    rollback = 0;
    run(n_if, nl + 1, 1, 10);
    lsb_wr = 0;
  endtask

  task automatic test_rdy();
    mc_lat = 4;
    resp_q.push_back(32'hA5A5A5A5); exp_if.push_back(32'hA5A5A5A5);
    exp_grant.push_back('{1'b0, 32'h6000, 3'd4, 32'h0, 1'b0});
    if_pc = 32'h6000; if_en = 1;
    tick();
    wait_mc_done(20);
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (if_done !== 0 || mc_en !== 1) begin
        failures++; $display("FAIL rdy_frozen got done=%b en=%b exp 0/1", if_done, mc_en);
      end
    end
    rdy = 1;
    tick();
    checks++;
    if (if_done !== 1 || if_data !== 32'hA5A5A5A5 || mc_en !== 0) begin
      failures++; $display("FAIL rdy_resume got done=%b data=%h en=%b exp 1/a5a5a5a5/0", if_done, if_data, mc_en);
    end
    if_en = 0;
    tick();
    checks++;
    if (if_done !== 0) begin failures++; $display("FAIL rdy_width got=%b exp=0", if_done); end
  endtask

  task automatic test_reset_mid();
    mc_lat = 30;
    exp_grant.push_back('{1'b0, 32'h7000, 3'd1, 32'h0, 1'b1});
    lsb_wr = 0; lsb_addr = 32'h7000; lsb_len = 3'd1; lsb_w_data = 32'h0; lsb_en = 1;
    tick();
    checks++;
    if (mc_en !== 1) begin failures++; $display("FAIL rm_grant got en=%b exp=1", mc_en); end
    tick(); tick();
    rst_n = 0; lsb_en = 0;
    tick();
    checks++;
    if ({mc_en, mc_wr, mc_len, if_done, lsb_done} !== 7'b0 || mc_addr !== 0 || mc_wdata !== 0 || if_data !== 0 || lsb_r_data !== 0) begin
      failures++; $display("FAIL rm_outputs got en=%b addr=%h if_data=%h exp all 0", mc_en, mc_addr, if_data);
    end
    rst_n = 1;
    tick();
    mc_lat = 3;
    resp_q.push_back(32'h0F0F0F0F); exp_if.push_back(32'h0F0F0F0F);
    exp_grant.push_back('{1'b0, 32'h8000, 3'd4, 32'h0, 1'b0});
    if_pc = 32'h8000; if_en = 1;
    run(n_if + 1, n_lsb, 1, 40);
  endtask

  initial begin
    test_reset();
    test_if_only();
    test_simultaneous();
    test_starvation();
    test_rollback_load();
    test_rollback_store();
    test_rdy();
    test_reset_mid();
    tick(); tick();
    checks++;
    if (exp_grant.size() != 0 || exp_if.size() != 0 || exp_lsb.size() != 0) begin
      failures++;
      $display("FAIL leftover got grant=%0d if=%0d lsb=%0d exp 0", exp_grant.size(), exp_if.size(), exp_lsb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
